// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT sizing, modulus and stage scheduler state encoding.
package ntt_pkg;
    localparam int LOG_N = 9;
    localparam int N = 1 << LOG_N;
    localparam int unsigned Q = 32'd268369921;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stage_state_t;
endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: valid+address shift register aligning write-back with butterfly output.
module ntt_wb_delay #(
    parameter int DEPTH = 10,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_addr_x,
    input  logic [W-1:0] in_addr_y,
    output logic         out_valid,
    output logic [W-1:0] out_addr_x,
    output logic [W-1:0] out_addr_y
);
    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0][W-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        v_d[0] = in_valid;
        x_d[0] = in_addr_x;
        y_d[0] = in_addr_y;
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            x_d[i] = x_q[i-1];
            y_d[i] = y_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            v_q <= v_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign out_valid  = v_q[DEPTH-1];
    assign out_addr_x = x_q[DEPTH-1];
    assign out_addr_y = y_q[DEPTH-1];
endmodule

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: issues per-stage butterfly read pairs and twiddle indices, then drains
// write-backs before starting the next stage so no stage reads data still in flight.
module ntt_stage_sched import ntt_pkg::*; #(
    parameter int LOG_N = ntt_pkg::LOG_N,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG_N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG_N-1:0]           rd_addr_x,
    output logic [LOG_N-1:0]           rd_addr_y,
    output logic [LOG_N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG_N-1:0]           wr_addr_x,
    output logic [LOG_N-1:0]           wr_addr_y
);
    localparam int D = RD_LAT + BF_LAT;
    localparam int SW = $clog2(LOG_N);
    localparam int KW = LOG_N - 1;

    stage_state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d, kk, wcnt_q, wcnt_d, tw_q, tw_d;
    logic [SW-1:0] stage_q, stage_d, nstage;
    logic [LOG_N-1:0] ax_q, ax_d, ay_q, ay_d, kx, m, x;
    logic busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, go;
    int sh;

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        stage_d = stage_q;
        wcnt_d = wr_en ? wcnt_q + KW'(1) : wcnt_q;
        rd_en_d = 1'b0;
        ax_d = ax_q;
        ay_d = ay_q;
        tw_d = tw_q;
        go = 1'b0;
        nstage = stage_q;
        case (state_q)
            IDLE: begin
                stage_d = '0;
                nstage = '0;
                go = start;
            end
            ISSUE: go = 1'b1;
            DRAIN: begin
                // Next stage may only read once its last write-back has landed
                if (wr_en && wcnt_q == '1) begin
                    if (stage_q == SW'(LOG_N - 1)) state_d = DONE;
                    else begin
                        go = 1'b1;
                        nstage = stage_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        kk = (state_q == ISSUE) ? k_q : '0;
        sh = LOG_N - 1 - int'(nstage);
        m = LOG_N'(1) << sh;
        kx = LOG_N'(kk);
        x = ((kx >> sh) << (sh + 1)) | (kx & (m - LOG_N'(1)));
        if (go) begin
            state_d = ISSUE;
            stage_d = nstage;
            k_d = kk;
            if (!hold) begin
                rd_en_d = 1'b1;
                ax_d = x;
                ay_d = x | m;
                tw_d = KW'((kx & (m - LOG_N'(1))) << nstage);
                k_d = kk + KW'(1);
                if (kk == '1) state_d = DRAIN;
            end
        end
        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q <= '0;
            wcnt_q <= '0;
            stage_q <= '0;
            tw_q <= '0;
            ax_q <= '0;
            ay_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            wcnt_q <= wcnt_d;
            stage_q <= stage_d;
            tw_q <= tw_d;
            ax_q <= ax_d;
            ay_q <= ay_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rd_en_q <= rd_en_d;
        end
    end

    ntt_wb_delay #(.DEPTH(D), .W(LOG_N)) u_wb (
        .clk(clk),
        .rst(rst),
        .in_valid(rd_en_q),
        .in_addr_x(ax_q),
        .in_addr_y(ay_q),
        .out_valid(wr_en),
        .out_addr_x(wr_addr_x),
        .out_addr_y(wr_addr_y)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign stage = stage_q;
    assign rd_en = rd_en_q;
    assign rd_addr_x = ax_q;
    assign rd_addr_y = ay_q;
    assign tw_addr = tw_q;
endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched: scoreboard bench for the stage scheduler at LOG_N=3 and LOG_N=9.
module tb_ntt_stage_sched;
    logic clk = 1'b0, rst = 1'b1, hold = 1'b0, start3 = 1'b0, start9 = 1'b0;
    logic busy3, done3, rd3, wr3, busy9, done9, rd9, wr9;
    logic [1:0] stage3, tw3;
    logic [2:0] rx3, ry3, wx3, wy3;
    logic [3:0] stage9;
    logic [7:0] tw9;
    logic [8:0] rx9, ry9, wx9, wy9;
    logic [63:0] rq3[$], wq3[$], rq9[$], wq9[$];
    int cyc = 0, n_tests = 0, n_fail = 0;
    int ndone3 = 0, ndone9 = 0, nwr3 = 0, nwr9 = 0, exp_done3 = 0, exp_done9 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_stage_sched #(.LOG_N(3), .RD_LAT(1), .BF_LAT(9)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .hold(hold), .busy(busy3), .done(done3),
        .stage(stage3), .rd_en(rd3), .rd_addr_x(rx3), .rd_addr_y(ry3), .tw_addr(tw3),
        .wr_en(wr3), .wr_addr_x(wx3), .wr_addr_y(wy3)
    );

    ntt_stage_sched #(.LOG_N(9), .RD_LAT(1), .BF_LAT(9)) dut9 (
        .clk(clk), .rst(rst), .start(start9), .hold(1'b0), .busy(busy9), .done(done9),
        .stage(stage9), .rd_en(rd9), .rd_addr_x(rx9), .rd_addr_y(ry9), .tw_addr(tw9),
        .wr_en(wr9), .wr_addr_x(wx9), .wr_addr_y(wy9)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int c, input int s, input int x, input int y, input int t);
        return {16'(c), 8'(s), 12'(x), 12'(y), 16'(t)};
    endfunction

    // Expected read/write stream from the address formulas; pairs issued after the hold window slip by hl
    task automatic model(input int ln, input int t0, input int hs, input int hl, output int dn);
        int n, d, per, m, e, x;
        n = 1 << ln;
        d = 10;
        per = n / 2 + d;
        for (int s = 0; s < ln; s++) begin
            m = n >> (s + 1);
            for (int g = 0; g < n / (2 * m); g++)
                for (int j = 0; j < m; j++) begin
                    e = t0 + 1 + s * per + g * m + j;
                    if (hl > 0 && e > hs) e += hl;
                    x = g * 2 * m + j;
                    if (ln == 3) begin
                        rq3.push_back(pk(e, s, x, x + m, j << s));
                        wq3.push_back(pk(e + d, s, x, x + m, 0));
                    end else begin
                        rq9.push_back(pk(e, s, x, x + m, j << s));
                        wq9.push_back(pk(e + d, s, x, x + m, 0));
                    end
                end
        end
        dn = t0 + 1 + ln * per + hl;
    endtask

    always @(negedge clk) begin
        if (rd3) begin
            if (rq3.size() == 0) check("rd3_extra", 1, 0);
            else check("rd3", pk(cyc, stage3, rx3, ry3, tw3), rq3.pop_front());
        end
        if (wr3) begin
            nwr3++;
            if (wq3.size() == 0) check("wr3_extra", 1, 0);
            else check("wr3", pk(cyc, stage3, wx3, wy3, 0), wq3.pop_front());
        end
        if (rd9) begin
            if (rq9.size() == 0) check("rd9_extra", 1, 0);
            else check("rd9", pk(cyc, stage9, rx9, ry9, tw9), rq9.pop_front());
        end
        if (wr9) begin
            nwr9++;
            if (wq9.size() == 0) check("wr9_extra", 1, 0);
            else check("wr9", pk(cyc, stage9, wx9, wy9, 0), wq9.pop_front());
        end
        if (done3) begin
            ndone3++;
            check("done3_cyc", cyc, exp_done3);
        end
        if (done9) begin
            ndone9++;
            check("done9_cyc", cyc, exp_done9);
        end
    end

    task automatic go(input int ln, input int hoff, input int hl, output int t0);
        int dn;
        @(negedge clk);
        #1;
        t0 = cyc;
        if (ln == 3) begin
            start3 = 1'b1;
            nwr3 = 0;
        end else begin
            start9 = 1'b1;
            nwr9 = 0;
        end
        model(ln, t0, t0 + hoff, hl, dn);
        if (ln == 3) exp_done3 = dn;
        else exp_done9 = dn;
        @(negedge clk);
        #1;
        start3 = 1'b0;
        start9 = 1'b0;
        check(ln == 3 ? "busy3_on" : "busy9_on", ln == 3 ? busy3 : busy9, 1);
    endtask

    task automatic finish_run(input int ln, input int prev, input int nwr_exp);
        int c = 0;
        while ((ln == 3 ? ndone3 : ndone9) == prev && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("done_timeout", (ln == 3 ? ndone3 : ndone9) > prev, 1);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", (ln == 3 ? ndone3 : ndone9) - prev, 1);
        check("busy_off", ln == 3 ? busy3 : busy9, 0);
        check("stage_idle", ln == 3 ? 64'(stage3) : 64'(stage9), 0);
        check("rdq_empty", ln == 3 ? rq3.size() : rq9.size(), 0);
        check("wrq_empty", ln == 3 ? wq3.size() : wq9.size(), 0);
        check("wr_cnt", ln == 3 ? nwr3 : nwr9, nwr_exp);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_rd", rd3, 0);
        check("rst_wr", wr3, 0);
        check("rst_stage", stage3, 0);
        check("rst_addr", {rx3, ry3, tw3, wx3, wy3}, 0);
        check("rst_busy9", busy9, 0);
        // plain run
        go(3, 0, 0, t0);
        finish_run(3, ndone3, 12);
        // hold for three cycles mid stage 0
        go(3, 2, 3, t0);
        @(negedge clk);
        #1;
        hold = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        hold = 1'b0;
        finish_run(3, ndone3, 12);
        // start pulses while busy must be ignored
        go(3, 0, 0, t0);
        repeat (2) @(negedge clk);
        #1;
        start3 = 1'b1;
        @(negedge clk);
        #1;
        start3 = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        start3 = 1'b1;
        @(negedge clk);
        #1;
        start3 = 1'b0;
        finish_run(3, ndone3, 12);
        // reset mid-transform discards everything in flight
        go(3, 0, 0, t0);
        repeat (19) @(negedge clk);
        #1;
        check("rst_mid_cyc", cyc, t0 + 20);
        rst = 1'b1;
        rq3.delete();
        wq3.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", busy3, 0);
        check("abort_wr", wr3, 0);
        check("abort_rd", rd3, 0);
        check("abort_stage", stage3, 0);
        check("abort_done", done3, 0);
        repeat (30) @(negedge clk);
        #1;
        check("abort_quiet_busy", busy3, 0);
        go(3, 0, 0, t0);
        finish_run(3, ndone3, 12);
        // full-size transform
        go(9, 0, 0, t0);
        finish_run(9, ndone9, 2304);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
